fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//   Instruction fetch stage ahead of the instruction ROM. Owns the program counter,
//   drives the ROM address, captures the 25-bit instruction word into an instruction
//   register (IR) and hands it to decode over a valid/ready handshake.
//   Handles stall back-pressure, branch/jump redirect, PC wrap-around and a HALT opcode.
// PARAMETERS
//   ADDR_W    8          PC / ROM address width
//   INSTR_W   25         instruction word width; opcode = instr[INSTR_W-1 -: 5]
//   RESET_PC  8'h00      PC value loaded on reset
//   HALT_OP   5'b11111   opcode that stops fetching
//   CNT_W     16         width of retired-fetch counter
// PORTS
//   clk              in   1        clock, all state on rising edge
//   rst_n            in   1        asynchronous reset, active low
//   rom_addr         out  ADDR_W   ROM address, = pc register (no comb path from inputs)
//   rom_data         in   INSTR_W  ROM word for rom_addr, valid in the same cycle
//   redirect_valid   in   1        branch/jump taken from execute, single-cycle pulse
//   redirect_target  in   ADDR_W   new PC when redirect_valid=1
//   ir_valid         out  1        IR holds an instruction for decode
//   ir_ready         in   1        decode accepts IR this cycle
//   ir_instr         out  INSTR_W  captured instruction word
//   ir_pc            out  ADDR_W   address the IR word was fetched from
//   halted           out  1        1 while in HALTED state
//   fetch_count      out  CNT_W    number of accepted handshakes (ir_valid & ir_ready)
// BEHAVIOUR
//   Reset (async assert, sync release): pc=RESET_PC, ir_valid=0, ir_instr=0, ir_pc=0,
//     state=RUN, halted=0, fetch_count=0. Reset mid-operation discards IR contents.
//   States: RUN, HALTED. halted = (state==HALTED), registered.
//   advance = (state==RUN) & (~ir_valid | ir_ready) & ~redirect_valid.
//   Each cycle, priority high to low:
//   1. redirect_valid=1 (any state): pc<=redirect_target, ir_valid<=0, state<=RUN.
//      An IR handshake in the same cycle still counts in fetch_count; word is dropped.
//   2. advance: ir_instr<=rom_data, ir_pc<=pc, ir_valid<=1, pc<=pc+1 (mod 2^ADDR_W,
//      0xFF->0x00, no flag). If rom_data opcode==HALT_OP: state<=HALTED, pc NOT
//      incremented (rom_addr frozen at HALT address).
//   3. ir_valid & ir_ready & ~advance: ir_valid<=0.
//   4. otherwise hold pc, IR, state (stall: ir_valid=1, ir_ready=0).
//   Latency: word at address A is in IR one cycle after rom_addr=A; with ir_ready held
//     high, one instruction per cycle; first IR valid 1 cycle after rst_n release.
//   HALTED: no fetch; the HALT word stays in IR until accepted, then ir_valid=0.
//     Only redirect or reset leaves HALTED.
//   ir_instr/ir_pc stable while ir_valid=1 and ir_ready=0.
//   fetch_count: +1 per accepted handshake, saturates at 2^CNT_W-1.
//   redirect_target is used as given; no range check (all values legal).
// TESTING
//   T1 reset: rst_n=0 mid-run -> same cycle ir_valid=0, halted=0, rom_addr=RESET_PC,
//      fetch_count=0; release with ir_ready=1 -> ir_pc 0,1,2 on next 3 cycles.
//   T2 stall: ir_ready=0 at ir_pc=5 for 3 cycles -> ir_pc/ir_instr hold, rom_addr=6;
//      ready=1 -> ir_pc=6 next cycle, fetch_count counts 5 once.
//   T3 redirect: redirect_valid=1, target=0x40 while ir_valid=1 -> next cycle
//      ir_valid=0, rom_addr=0x40; following cycle ir_pc=0x40, ir_instr=ROM[0x40].
//   T4 wrap: run from pc=0xFE with ready=1 -> ir_pc 0xFE, 0xFF, 0x00 consecutively.
//   T5 halt: ROM[3] opcode=5'b11111 -> ir_pc=3, halted=1 next cycle, rom_addr stays 3,
//      ir_valid drops after accept; redirect to 0x10 -> halted=0, ir_pc=0x10 later.
//   T6 redirect + stall same cycle: ir_ready=0, redirect_valid=1 target=0x20 ->
//      IR dropped (ir_valid=0), fetch_count unchanged, then ir_pc=0x20.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, addresses the instruction
// ROM, captures the fetched word into the instruction register (IR) and offers
// it to decode over a valid/ready handshake. Handles stalls, branch/jump
// redirects, PC wrap-around and the HALT opcode, and counts accepted handshakes.
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 25,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
    parameter logic [4:0]        HALT_OP  = 5'b11111,
    parameter int                CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [INSTR_W-1:0] ir_instr,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_count
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_ir_valid;
    logic [INSTR_W-1:0]  r_ir_instr;
    logic [ADDR_W-1:0]   r_ir_pc;
    logic [CNT_W-1:0]    r_fetch_count;

    logic                w_advance;
    logic                w_accept;
    logic                w_is_halt;
    logic                w_cnt_max;

    // Handshake, fetch-enable and HALT-opcode decode shared by every process.
    assign w_accept  = r_ir_valid & ir_ready;
    assign w_advance = (r_state == ST_RUN) & (~r_ir_valid | ir_ready) & ~redirect_valid;
    assign w_is_halt = (rom_data[INSTR_W-1 -: 5] == HALT_OP);
    assign w_cnt_max = &r_fetch_count;

    // State register for the RUN/HALTED machine.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a redirect always resumes fetching; a fetched HALT word stops it.
    always_comb begin
        // NOTE: the default first keeps every path assigned, so no latch is inferred.
        w_state_next = r_state;
        if (redirect_valid) begin
            w_state_next = ST_RUN;
        end else if (w_advance && w_is_halt) begin
            w_state_next = ST_HALTED;
        end
    end

    // Outputs: ROM address and halt flag come straight from registers.
    always_comb begin
        rom_addr    = r_pc;
        halted      = (r_state == ST_HALTED);
        ir_valid    = r_ir_valid;
        ir_instr    = r_ir_instr;
        ir_pc       = r_ir_pc;
        fetch_count = r_fetch_count;
    end

    // Program counter: redirect wins, otherwise step on a fetch unless the
    // word is HALT, which leaves the address parked on the HALT instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_target;
        end else if (w_advance && !w_is_halt) begin
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    // Instruction register: load on fetch, drop on redirect or on accept
    // without a refill, otherwise hold so decode sees a stable word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir_valid <= 1'b0;
            r_ir_instr <= '0;
            r_ir_pc    <= '0;
        end else if (redirect_valid) begin
            r_ir_valid <= 1'b0;
        end else if (w_advance) begin
            r_ir_valid <= 1'b1;
            r_ir_instr <= rom_data;
            r_ir_pc    <= r_pc;
        end else if (w_accept) begin
            r_ir_valid <= 1'b0;
        end
    end

    // Retired-fetch counter: one per accepted handshake, even when a redirect
    // drops the word in the same cycle; sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= '0;
        end else if (w_accept && !w_cnt_max) begin
            r_fetch_count <= r_fetch_count + CNT_W'(1);
        end
    end

endmodule
